// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared definitions for the iterative InvSubBytes stage.
//   AES_STATE_W : width of one AES state (128 bits)
//   BYTE_W      : width of one state byte
//   state_e     : FSM encoding of inv_sub_bytes_iter
package inv_sub_bytes_iter_pkg;

  localparam int AES_STATE_W = 128;
  localparam int BYTE_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// AES inverse S-box, purely combinational.
// Ports:
//   in_i  [7:0] : byte to substitute
//   out_o [7:0] : InvSbox(in_i)
module inv_sub_bytes_iter_inv_sbox
  import inv_sub_bytes_iter_pkg::*;
(
  input  logic [BYTE_W-1:0] in_i,
  output logic [BYTE_W-1:0] out_o
);

  // Entry 0x00 sits in the top byte; entry x lives at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  // 255 - x == ~x for an 8-bit x, so the bit offset is {~x, 3'b000}.
  logic [10:0] bit_ofs;

  assign bit_ofs = {~in_i, 3'b000};
  assign out_o   = INV_SBOX_TABLE[bit_ofs +: BYTE_W];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes the 16 bytes of an AES state through
// NUM_SBOX inverse S-boxes, NUM_SBOX bytes per cycle, starting at byte 0
// (in_state[127:120]). One block every ITER+2 cycles.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds valid and data stable until that edge.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_state    : upstream (InvShiftRows) handshake + data
//   out_valid/out_ready/out_state : downstream (AddRoundKey) handshake + data
//   busy         : substitution in progress
//   dbg_state_o  : current FSM state (state_e encoding)
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy,
  output logic [1:0]             dbg_state_o
);

  localparam int ITER  = 16 / NUM_SBOX;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_cfg
    $error("inv_sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;

  logic [BYTE_W-1:0] sbox_in  [NUM_SBOX];
  logic [BYTE_W-1:0] sbox_out [NUM_SBOX];

  // Sbox g handles byte cnt*NUM_SBOX + g of the working register.
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    assign sbox_in[g] =
      work_q[(AES_STATE_W - 1) - (int'(cnt_q) * NUM_SBOX + g) * BYTE_W -: BYTE_W];

    inv_sub_bytes_iter_inv_sbox u_inv_sbox (
      .in_i  (sbox_in[g]),
      .out_o (sbox_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        for (int g = 0; g < NUM_SBOX; g++) begin
          work_d[(AES_STATE_W - 1) - (int'(cnt_q) * NUM_SBOX + g) * BYTE_W -: BYTE_W] =
            sbox_out[g];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // work_q only changes in IDLE (load) and BUSY, so it is stable through DONE.
  assign out_state   = work_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
module tb_inv_sub_bytes_iter;

  localparam int MAX_WAIT = 40;

  localparam logic [127:0] ALL_63 = {16{8'h63}};
  localparam logic [127:0] ALL_52 = {16{8'h52}};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   dbg_state;

  // Sweep instances: index 0..3 -> NUM_SBOX 1, 2, 8, 16
  logic [3:0]   sw_in_valid;
  logic [3:0]   sw_in_ready;
  logic [3:0]   sw_out_valid;
  logic [3:0]   sw_busy;
  logic [127:0] sw_out_state [4];
  logic [1:0]   sw_dbg [4];

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.NUM_SBOX(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  inv_sub_bytes_iter #(.NUM_SBOX(1)) dut_n1 (
    .clk(clk), .rst(rst),
    .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]), .in_state(ALL_63),
    .out_valid(sw_out_valid[0]), .out_ready(1'b1), .out_state(sw_out_state[0]),
    .busy(sw_busy[0]), .dbg_state_o(sw_dbg[0])
  );

  inv_sub_bytes_iter #(.NUM_SBOX(2)) dut_n2 (
    .clk(clk), .rst(rst),
    .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]), .in_state(ALL_63),
    .out_valid(sw_out_valid[1]), .out_ready(1'b1), .out_state(sw_out_state[1]),
    .busy(sw_busy[1]), .dbg_state_o(sw_dbg[1])
  );

  inv_sub_bytes_iter #(.NUM_SBOX(8)) dut_n8 (
    .clk(clk), .rst(rst),
    .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]), .in_state(ALL_63),
    .out_valid(sw_out_valid[2]), .out_ready(1'b1), .out_state(sw_out_state[2]),
    .busy(sw_busy[2]), .dbg_state_o(sw_dbg[2])
  );

  inv_sub_bytes_iter #(.NUM_SBOX(16)) dut_n16 (
    .clk(clk), .rst(rst),
    .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]), .in_state(ALL_63),
    .out_valid(sw_out_valid[3]), .out_ready(1'b1), .out_state(sw_out_state[3]),
    .busy(sw_busy[3]), .dbg_state_o(sw_dbg[3])
  );

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the
  // accepting edge.
  task automatic drive_accept(input logic [127:0] st);
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen, and samples spent busy.
  task automatic wait_done(output int edges, output int busy_samples);
    edges        = 0;
    busy_samples = 0;
    while (!out_valid && edges < MAX_WAIT) begin
      if (busy) busy_samples++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_state !== 128'h0) begin failures++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (sw_in_ready !== 4'hf) begin failures++; $display("FAIL reset_sweep_in_ready got=%b exp=1111", sw_in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_63();
    int edges, nbusy;
    drive_accept(ALL_63);
    wait_done(edges, nbusy);
    checks++; if (edges + 1 !== 5) begin failures++; $display("FAIL latency_n4 got=%0d exp=5", edges + 1); end
    checks++; if (nbusy !== 4) begin failures++; $display("FAIL busy_cycles_n4 got=%0d exp=4", nbusy); end
    checks++; if (out_state !== 128'h0) begin failures++; $display("FAIL result_all63 got=%h exp=0", out_state); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL done_in_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL return_idle got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_byte_order();
    int edges, nbusy;
    drive_accept(128'h00000000_00000000_00000000_000000FF);
    wait_done(edges, nbusy);
    checks++;
    if (out_state !== 128'h52525252_52525252_52525252_5252527D) begin
      failures++; $display("FAIL byte_order got=%h exp=%h", out_state, 128'h52525252_52525252_52525252_5252527D);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int edges, nbusy;
    logic [127:0] exp_v;
    exp_v = 128'h32325252_52525252_52525252_525252FF;
    out_ready = 1'b0;
    drive_accept(128'h23230000_00000000_00000000_00000016);
    in_state = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;  // must be ignored while busy
    wait_done(edges, nbusy);
    in_state = 128'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_state !== exp_v || in_ready !== 1'b0) begin
        failures++; $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b st=%h exp v=1 r=0 st=%h", i, out_valid, in_ready, out_state, exp_v);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL after_pulse got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = {16{8'hA5}};
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL second_accept got busy=%b exp=1", busy); end
    wait_done(edges, nbusy);
    checks++; if (out_state !== ALL_52) begin failures++; $display("FAIL second_result got=%h exp=%h", out_state, ALL_52); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    int edges, nbusy;
    drive_accept(ALL_63);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;  // no clock edge between rst rising and these samples
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL async_reset got busy=%b v=%b exp 0 0", busy, out_valid); end
    checks++; if (in_ready !== 1'b1 || out_state !== 128'h0) begin failures++; $display("FAIL async_reset_regs got r=%b st=%h exp r=1 st=0", in_ready, out_state); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_accept(128'h0);
    wait_done(edges, nbusy);
    checks++; if (out_state !== ALL_52 || edges + 1 !== 5) begin failures++; $display("FAIL post_reset_block got=%h lat=%0d exp=%h lat=5", out_state, edges + 1, ALL_52); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_param_sweep();
    int exp_lat [4];
    int edges;
    exp_lat[0] = 17; exp_lat[1] = 9; exp_lat[2] = 3; exp_lat[3] = 2;
    for (int k = 0; k < 4; k++) begin
      sw_in_valid[k] = 1'b1;
      @(posedge clk);
      #1;
      sw_in_valid[k] = 1'b0;
      edges = 0;
      while (!sw_out_valid[k] && edges < MAX_WAIT) begin
        @(posedge clk);
        #1;
        edges++;
      end
      checks++;
      if (edges + 1 !== exp_lat[k] || sw_out_state[k] !== 128'h0) begin
        failures++; $display("FAIL sweep_%0d got lat=%0d st=%h exp lat=%0d st=0", k, edges + 1, sw_out_state[k], exp_lat[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_state    = '0;
    out_ready   = 1'b1;
    sw_in_valid = '0;
    test_reset();
    test_all_63();
    test_byte_order();
    test_backpressure();
    test_reset_mid_op();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
